// File: rtl/usb_line_rx.sv
// USB receive front-end: pad synchroniser, J/K/SE0/SE1 decode, glitch filter,
// bit-centre DPLL strobe and bus-reset (long SE0) detection.
module usb_line_rx #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned FILTER_LEN   = 2,
  parameter bit          LOW_SPEED    = 1'b1,
  parameter int unsigned RESET_CLKS   = 38
) (
  input  logic clk,
  input  logic rst,
  input  logic i_dp,
  input  logic i_dn,
  output logic o_usb_j_not_k,
  output logic o_usb_se0,
  output logic o_usb_se1,
  output logic o_bit_strobe,
  output logic o_line_reset
);

  typedef enum logic [1:0] {LineJ, LineK, LineSe0, LineSe1} line_e;

  // Pad levels that encode J for the selected speed.
  localparam logic JDp = LOW_SPEED ? 1'b0 : 1'b1;
  localparam logic JDn = LOW_SPEED ? 1'b1 : 1'b0;

  localparam logic [2:0]  FilterLen  = 3'(FILTER_LEN);
  localparam logic [5:0]  PhaseLast  = 6'(CLKS_PER_BIT - 1);
  localparam logic [5:0]  PhaseMid   = 6'(CLKS_PER_BIT / 2);
  localparam logic [15:0] ResetClks  = 16'(RESET_CLKS);

  logic dp_meta_q, dp_sync_q, dn_meta_q, dn_sync_q;

  line_e       raw, raw_q, filt_q, filt_d;
  logic [2:0]  stab_q, stab_d;
  logic [5:0]  phase_q, phase_d;
  logic        strobe_q, strobe_d;
  logic        j_q, j_d;
  logic [15:0] se0_cnt_q, se0_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_meta_q <= JDp;
      dp_sync_q <= JDp;
      dn_meta_q <= JDn;
      dn_sync_q <= JDn;
    end else begin
      dp_meta_q <= i_dp;
      dp_sync_q <= dp_meta_q;
      dn_meta_q <= i_dn;
      dn_sync_q <= dn_meta_q;
    end
  end

  always_comb begin
    raw = LineJ;
    if (dp_sync_q == dn_sync_q) begin
      raw = dp_sync_q ? LineSe1 : LineSe0;
    end else begin
      raw = (dp_sync_q == JDp) ? LineJ : LineK;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q     <= LineJ;
      stab_q    <= '0;
      filt_q    <= LineJ;
      phase_q   <= '0;
      strobe_q  <= 1'b0;
      j_q       <= 1'b1;
      se0_cnt_q <= '0;
    end else begin
      raw_q     <= raw;
      stab_q    <= stab_d;
      filt_q    <= filt_d;
      phase_q   <= phase_d;
      strobe_q  <= strobe_d;
      j_q       <= j_d;
      se0_cnt_q <= se0_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    stab_d    = stab_q;
    filt_d    = filt_q;
    phase_d   = phase_q;
    strobe_d  = 1'b0;
    j_d       = j_q;
    se0_cnt_d = se0_cnt_q;

    if (raw != raw_q) begin
      stab_d = 3'd1;
    end else if (stab_q != FilterLen) begin
      stab_d = stab_q + 3'd1;
    end

    if (stab_d == FilterLen && raw != filt_q) begin
      filt_d = raw;
    end

    // A filtered transition realigns the phase and so suppresses a coincident strobe.
    if (filt_d != filt_q || phase_q == PhaseLast) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 6'd1;
    end
    strobe_d = (phase_d == PhaseMid);

    unique case (filt_d)
      LineJ:   j_d = 1'b1;
      LineK:   j_d = 1'b0;
      default: j_d = j_q;
    endcase

    if (filt_q != LineSe0) begin
      se0_cnt_d = '0;
    end else if (se0_cnt_q != ResetClks) begin
      se0_cnt_d = se0_cnt_q + 16'd1;
    end
  end

  // Outputs.
  always_comb begin
    o_usb_j_not_k = j_q;
    o_usb_se0     = (filt_q == LineSe0);
    o_usb_se1     = (filt_q == LineSe1);
    o_bit_strobe  = strobe_q;
    o_line_reset  = (se0_cnt_q == ResetClks);
  end

endmodule

// File: tb/tb_usb_line_rx.sv
// Directed bench for usb_line_rx with default parameters (low speed: J = D- high).
module tb_usb_line_rx;

  logic clk, rst, i_dp, i_dn;
  logic o_usb_j_not_k, o_usb_se0, o_usb_se1, o_bit_strobe, o_line_reset;

  int n_checks = 0;
  int n_errors = 0;

  usb_line_rx dut (
    .clk           (clk),
    .rst           (rst),
    .i_dp          (i_dp),
    .i_dn          (i_dn),
    .o_usb_j_not_k (o_usb_j_not_k),
    .o_usb_se0     (o_usb_se0),
    .o_usb_se1     (o_usb_se1),
    .o_bit_strobe  (o_bit_strobe),
    .o_line_reset  (o_line_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then sit 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pads_j();   i_dp = 1'b0; i_dn = 1'b1; endtask
  task automatic pads_k();   i_dp = 1'b1; i_dn = 1'b0; endtask
  task automatic pads_se0(); i_dp = 1'b0; i_dn = 1'b0; endtask
  task automatic pads_se1(); i_dp = 1'b1; i_dn = 1'b1; endtask

  initial begin
    rst = 1'b1;
    pads_j();
    #1;
    check("rst_j", o_usb_j_not_k, 1);
    check("rst_se0", o_usb_se0, 0);
    check("rst_se1", o_usb_se1, 0);
    check("rst_strobe", o_bit_strobe, 0);
    check("rst_line_reset", o_line_reset, 0);
    step(2);
    rst = 1'b0;
    step(7);

    // Clean J->K change: output follows 4 edges after the pad.
    pads_k();
    step(3);
    check("k_latency_before", o_usb_j_not_k, 1);
    step(1);
    check("k_latency_at", o_usb_j_not_k, 0);
    check("k_no_strobe_at_change", o_bit_strobe, 0);
    for (int k = 1; k <= 25; k++) begin
      step(1);
      check("k_strobe", o_bit_strobe, 32'((k % 10) == 5));
    end

    // Back to J, then a single-cycle K glitch that must be filtered out.
    pads_j();
    step(3);
    check("j_return_before", o_usb_j_not_k, 0);
    step(1);
    check("j_return_at", o_usb_j_not_k, 1);
    for (int k = 1; k <= 30; k++) begin
      step(1);
      check("glitch_strobe", o_bit_strobe, 32'((k % 10) == 5));
      check("glitch_j", o_usb_j_not_k, 1);
      check("glitch_se0", o_usb_se0, 0);
      if (k == 12) pads_k();
      if (k == 13) pads_j();
    end

    // J/K stream with an 11-cycle bit period: filtered edges at k = 4, 15, 26, 37, 48.
    pads_k();
    for (int k = 1; k <= 50; k++) begin
      step(1);
      check("stream_strobe", o_bit_strobe, 32'(k >= 4 && ((k - 4) % 11) == 5));
      check("stream_j", o_usb_j_not_k, (k < 4) ? 32'd1 : 32'((((k - 4) / 11) % 2) == 1));
      if (k == 11 || k == 33) pads_j();
      if (k == 22 || k == 44) pads_k();
    end

    // Phase is 2 here; a filtered edge at m = 13 collides with phase 5.
    for (int m = 1; m <= 25; m++) begin
      step(1);
      check("collide_strobe", o_bit_strobe, 32'(m == 3 || m == 18));
      check("collide_j", o_usb_j_not_k, (m < 13) ? 32'd0 : 32'd1);
      if (m == 9) pads_j();
    end

    // SE0 for 50 cycles: filtered SE0 at n = 4, line reset from n = 42 until n = 54.
    pads_se0();
    for (int n = 1; n <= 56; n++) begin
      step(1);
      check("se0_level", o_usb_se0, 32'(n >= 4 && n < 54));
      check("se0_line_reset", o_line_reset, 32'(n >= 42 && n <= 54));
      check("se0_j_hold", o_usb_j_not_k, 1);
      if (n == 50) pads_j();
    end

    // From K, SE1 for 10 cycles: j_not_k holds 0, DPLL realigns on entry and exit.
    pads_k();
    step(6);
    check("pre_se1_j", o_usb_j_not_k, 0);
    pads_se1();
    for (int p = 1; p <= 16; p++) begin
      step(1);
      check("se1_level", o_usb_se1, 32'(p >= 4 && p < 14));
      check("se1_se0", o_usb_se0, 0);
      check("se1_j_hold", o_usb_j_not_k, 0);
      check("se1_strobe", o_bit_strobe, 32'(p == 3 || p == 9));
      if (p == 10) pads_k();
    end

    // Asynchronous reset mid-K: outputs return before any clock edge.
    rst = 1'b1;
    #1;
    check("async_rst_j", o_usb_j_not_k, 1);
    check("async_rst_se1", o_usb_se1, 0);
    check("async_rst_strobe", o_bit_strobe, 0);
    check("async_rst_line_reset", o_line_reset, 0);
    pads_j();
    step(2);
    rst = 1'b0;
    for (int r = 1; r <= 26; r++) begin
      step(1);
      check("post_rst_strobe", o_bit_strobe, 32'(r == 5 || r == 15 || r == 25));
      check("post_rst_j", o_usb_j_not_k, 1);
      check("post_rst_se0", o_usb_se0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_line_rx.md
Name: usb_line_rx

Overview:
- Receive front-end between the raw USB D+/D- pads and the USB subsystem's line-state inputs.
- Double-flops both async pad inputs and decodes them into J/K/SE0/SE1 line states.
- Applies a glitch filter, then runs a digital PLL that emits one strobe per bit at the bit centre.
- Detects USB bus reset (long SE0).
- Drives the subsystem's i_usb_j_not_k / i_usb_se0 with clean, synchronous levels.

Parameters:
- CLKS_PER_BIT, 10, clk cycles per USB bit (15 MHz / 1.5 Mbps low-speed); legal range 4..63.
- FILTER_LEN, 2, consecutive identical synchronised samples required before the filtered state changes; legal range 1..7.
- LOW_SPEED, 1, 1: J = D- high, D+ low; 0: J = D+ high, D- low.
- RESET_CLKS, 38, consecutive filtered-SE0 cycles that flag bus reset (2.5 us at 15 MHz); legal range 1..65535.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_dp  input  1  raw D+ pad level, asynchronous to clk.
- i_dn  input  1  raw D- pad level, asynchronous to clk.
- o_usb_j_not_k  output  1  filtered level, 1 = J, 0 = K; holds its last value during SE0/SE1.
- o_usb_se0  output  1  filtered state is SE0.
- o_usb_se1  output  1  filtered state is SE1 (illegal line state).
- o_bit_strobe  output  1  one-cycle pulse at the bit-centre sample point.
- o_line_reset  output  1  bus reset detected; level output.

Behaviour:
- Reset values while rst is high: sync flops = J encoding; filtered state = J; o_usb_j_not_k = 1; o_usb_se0 = 0; o_usb_se1 = 0; o_bit_strobe = 0; o_line_reset = 0; phase counter = 0; stability and SE0 counters = 0.
- Reset takes effect immediately (async); first update occurs on the first rising edge after release.
- Synchroniser: two flops on each of i_dp and i_dn. Output "raw" is decoded to one of four states: J, K, SE0 (both low), SE1 (both high).
- Filter:
  - Stability counter resets to 1 whenever raw differs from raw of the previous cycle; otherwise it increments, saturating at FILTER_LEN.
  - Filtered state takes raw on the edge after the counter equals FILTER_LEN while raw differs from the filtered state.
  - Pad-to-output latency for a clean change: FILTER_LEN+2 clk edges.
  - Pulses shorter than FILTER_LEN raw cycles never reach the outputs.
- Outputs are registered directly from the filtered state; no combinational path from pads to outputs.
- DPLL phase counter:
  - Increments each cycle and wraps from CLKS_PER_BIT-1 to 0.
  - Loads 0 on any edge where the filtered state changes (edge realignment).
  - o_bit_strobe = 1 in the cycle the counter equals CLKS_PER_BIT/2 (integer division).
  - Conflict rule: if a filtered transition occurs in the same cycle the counter would reach the strobe value, the transition wins. The counter loads 0 and no strobe is issued.
  - Strobes continue free-running during idle, SE0 and SE1.
- SE0 counter:
  - Counts cycles of continuous filtered SE0, saturating at RESET_CLKS.
  - Clears to 0 whenever the filtered state is not SE0.
  - o_line_reset = 1 exactly while the counter equals RESET_CLKS.
  - Deasserts on the edge after the filtered state leaves SE0.
- SE1 behaviour: o_usb_se1 = 1 and o_usb_se0 = 0; o_usb_j_not_k holds its value; DPLL realigns on entry and exit as for any state change.

Test Plan:
- Idle J, then pads switch to K and hold for 30 cycles. Required: o_usb_j_not_k falls exactly 4 edges after the pad change (FILTER_LEN=2); o_bit_strobe pulses 5 cycles after the filtered change, then every 10 cycles.
- Idle J with a 1-cycle K glitch on the pads. Required: no change on any output; strobe spacing stays 10 cycles, with no realignment.
- Bit stream J,K,J,K with an 11-cycle bit period. Required: every strobe occurs 5 cycles after the most recent filtered transition, with no missing or double strobes.
- Transition timed to land on the phase-5 cycle. Required: no strobe in that cycle; the next strobe comes 5 cycles later.
- SE0 held for 50 cycles, then J. Required: o_usb_se0 = 1 throughout; o_line_reset rises after 38 filtered-SE0 cycles and falls one edge after filtered J.
- SE1 for 10 cycles. Required: o_usb_se1 = 1 and o_usb_j_not_k unchanged.
- Assert rst mid-stream during K. Required: all outputs return to reset values without waiting for a clock edge; after release, J on the pads yields clean strobes.
